// File: rtl/demux16b3_buf.sv
// demux16b3_buf: registered 1-to-3 demultiplexer for the 16-bit datapath.
//
// One word plus a 2-bit destination select is accepted through a valid/ready
// handshake, held in a one-entry buffer and presented to exactly one of three
// consumers, each with its own valid/ready handshake. Select value 3 is illegal.
// An illegal word is consumed and dropped. It sets a sticky error flag and bumps
// a saturating drop counter.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   in_data      word to steer
//   in_sel       destination (0..2 legal, 3 illegal)
//   in_valid     in_data/in_sel valid this cycle
//   in_ready     block can accept this cycle
//   outN_data    word for destination N (zero unless outN_valid)
//   outN_valid   outN_data valid
//   outN_ready   destination N accepts
//   err          sticky illegal-select flag
//   err_clr      clears err (an illegal accept in the same cycle wins)
//   drop_count   number of illegal-select words dropped, saturating

module demux16b3_buf #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic             err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] drop_count
);

    typedef enum logic [0:0] {
        StEmpty,
        StFull
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   buf_data_q, buf_data_d;
    logic [1:0]         buf_sel_q, buf_sel_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   drop_q, drop_d;

    logic               sel_ready;
    logic               accept;
    logic               accept_legal;
    logic               accept_illegal;

    // Ready of the destination the held word is aimed at; other readys are ignored.
    always_comb begin
        sel_ready = 1'b0;
        case (buf_sel_q)
            2'd0:    sel_ready = out0_ready;
            2'd1:    sel_ready = out1_ready;
            2'd2:    sel_ready = out2_ready;
            default: sel_ready = 1'b0;
        endcase
    end

    // Depends only on state and the selected ready, never on in_valid.
    assign in_ready       = (state_q == StEmpty) || sel_ready;
    assign accept         = in_valid && in_ready;
    assign accept_legal   = accept && (in_sel != 2'd3);
    assign accept_illegal = accept && (in_sel == 2'd3);

    // Next-state logic for the buffer FSM and status registers.
    always_comb begin
        state_d    = state_q;
        buf_data_d = buf_data_q;
        buf_sel_d  = buf_sel_q;
        err_d      = err_q;
        drop_d     = drop_q;

        case (state_q)
            StEmpty: begin
                if (accept_legal) begin
                    state_d    = StFull;
                    buf_data_d = in_data;
                    buf_sel_d  = in_sel;
                end
            end
            StFull: begin
                // Drain and reload in the same cycle keeps one word per cycle flowing.
                if (sel_ready) begin
                    if (accept_legal) begin
                        buf_data_d = in_data;
                        buf_sel_d  = in_sel;
                    end else begin
                        state_d = StEmpty;
                    end
                end
            end
            default: state_d = StEmpty;
        endcase

        if (accept_illegal) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end

        if (accept_illegal && (drop_q != {CNT_W{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StEmpty;
            buf_data_q <= '0;
            buf_sel_q  <= '0;
            err_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            buf_data_q <= buf_data_d;
            buf_sel_q  <= buf_sel_d;
            err_q      <= err_d;
            drop_q     <= drop_d;
        end
    end

    // Only the selected destination sees the word; every other output is zero.
    always_comb begin
        out0_data  = '0;
        out0_valid = 1'b0;
        out1_data  = '0;
        out1_valid = 1'b0;
        out2_data  = '0;
        out2_valid = 1'b0;
        if (state_q == StFull) begin
            case (buf_sel_q)
                2'd0: begin
                    out0_data  = buf_data_q;
                    out0_valid = 1'b1;
                end
                2'd1: begin
                    out1_data  = buf_data_q;
                    out1_valid = 1'b1;
                end
                2'd2: begin
                    out2_data  = buf_data_q;
                    out2_valid = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign err        = err_q;
    assign drop_count = drop_q;

endmodule
